mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store engine of the pipelined core.
- Sits between the EX/MEM pipeline register and the D-cache.
- Its registered load result feeds the MEM/WB register's MemReadData input.
- Handles byte/halfword/word loads with sign/zero extension; sub-word stores via read-modify-write on the word-only D-cache; stalls the pipeline while the cache is busy.

Parameters:
MAX_WAIT, 255, cycles a single cache request may stay pending before Timeout_o sets (8-bit wait counter)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-low reset
MemRead_i  input  1  load request from EX/MEM
MemWrite_i  input  1  store request from EX/MEM
Funct3_i  input  3  access size/sign (RISC-V funct3)
MemAddr_i  input  32  byte address
MemWriteData_i  input  32  store data (rs2)
MemReadData_o  output  32  formatted load result to MEM/WB
Stall_o  output  1  freeze PC/IF/ID/EX/MEM registers; MEM/WB not stalled
Misaligned_o  output  1  one-cycle pulse: misaligned/illegal access
Timeout_o  output  1  sticky: a request exceeded MAX_WAIT
DCACHE_ren_o  output  1  cache read request (registered)
DCACHE_wen_o  output  1  cache write request (registered)
DCACHE_addr_o  output  30  word address = MemAddr_i[31:2]
DCACHE_wdata_o  output  32  cache write word
DCACHE_rdata_i  input  32  cache read word
DCACHE_stall_i  input  1  cache busy; request completes in first cycle it is low

Behaviour:
- Reset (async, rst_i=0): state IDLE; MemReadData_o=0, Stall_o=0, Misaligned_o=0, Timeout_o=0, DCACHE_ren_o=0, DCACHE_wen_o=0, DCACHE_addr_o=0, DCACHE_wdata_o=0, wait counter=0. An in-flight request is dropped; the cache is reset by the same rst_i.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- Stall_o is combinational: 1 in IDLE when MemRead_i|MemWrite_i; 1 in RD/WR/RMW_RD/RMW_WR; 0 in DONE.
- IDLE, request seen: latch addr, funct3, wdata; check legality.
  - Illegal: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0; funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores; MemRead_i and MemWrite_i both 1.
  - Illegal → DONE; Misaligned_o=1 for that one cycle; MemReadData_o<=0; no cache access.
  - Legal load → RD. SW → WR. SB/SH → RMW_RD.
  - Cache request registers are asserted on entry to the target state.
- RD / RMW_RD: DCACHE_ren_o=1 held until a cycle with DCACHE_stall_i=0. In that cycle capture DCACHE_rdata_i and drop ren.
  - RD → DONE; MemReadData_o<=formatted data.
  - RMW_RD → RMW_WR; DCACHE_wdata_o<=merged word; wen=1.
- WR / RMW_WR: DCACHE_wen_o=1 held until DCACHE_stall_i=0, then drop wen → DONE.
- DONE: one cycle; Stall_o=0 so the pipeline advances → IDLE. MemReadData_o is held until the next load completes.
- Minimum latencies: legal load/SW occupy 3 cycles (IDLE, req, DONE); SB/SH 4 cycles; illegal access 2 cycles.
- Load format: little-endian lanes, byte k = bits[8k+7:8k], k=addr[1:0].
  - LB/LBU: lane k, sign/zero-extend.
  - LH/LHU: half addr[1] (bits 15:0 or 31:16), sign/zero-extend.
  - LW: whole word.
- Store merge: SB replaces lane k with wdata[7:0]; SH replaces half addr[1] with wdata[15:0]; other bytes come from the read word.
- Wait counter: counts consecutive cycles with a request asserted and DCACHE_stall_i=1; clears on completion.
  - When it reaches MAX_WAIT, Timeout_o sets and stays 1 until reset.
  - The request keeps waiting; no abort.
- Inputs are ignored outside IDLE; EX/MEM is held by Stall_o, so they stay stable.

Test Plan:
- Load hit path: MemRead, LW, addr 0x0000_0104, cache rdata 0xDEADBEEF, stall_i=0 → DCACHE_addr_o=0x41, Stall_o high 2 cycles, MemReadData_o=0xDEADBEEF in DONE.
- Sub-word loads on word 0x8070_F0A5:
  - LB @+0 → 0xFFFF_FFA5
  - LBU @+3 → 0x0000_0080
  - LH @+2 → 0xFFFF_8070
  - LHU @+0 → 0x0000_F0A5
- SB read-modify-write: old word 0x1122_3344, SB addr+1 data 0xAB → ren then wen cycles, DCACHE_wdata_o=0x1122_AB44, 4 stall-related cycles.
- Cache miss: stall_i held high 20 cycles during RD → ren held, Stall_o high throughout, completes cycle after stall_i falls. Repeat with MAX_WAIT=4 and 10 stall cycles → Timeout_o=1 and remains 1.
- Misaligned: LW addr 0x102 and SH addr 0x101 → Misaligned_o one-cycle pulse, no ren/wen, MemReadData_o=0, Stall_o=1 exactly one cycle.
- Reset mid-RMW: assert rst_i=0 during RMW_RD → all outputs 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store engine. Sits between the EX/MEM pipeline register and a
// word-only D-cache. Loads are formatted (byte/halfword lane select with sign or
// zero extension) into a registered result for MEM/WB. Sub-word stores are
// performed as a read-modify-write of the containing word. The pipeline is
// stalled while a request is in flight.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-low reset
//   MemRead_i           load request from EX/MEM
//   MemWrite_i          store request from EX/MEM
//   Funct3_i            RISC-V funct3 (access size / sign)
//   MemAddr_i           byte address
//   MemWriteData_i      store data (rs2)
//   MemReadData_o       formatted load result to MEM/WB (held between loads)
//   Stall_o             freeze PC/IF/ID/EX/MEM (combinational)
//   Misaligned_o        one-cycle pulse on a misaligned or illegal access
//   Timeout_o           sticky: a cache request waited MAX_WAIT cycles
//   DCACHE_ren_o        cache read request (registered)
//   DCACHE_wen_o        cache write request (registered)
//   DCACHE_addr_o       cache word address (MemAddr_i[31:2])
//   DCACHE_wdata_o      cache write word
//   DCACHE_rdata_i      cache read word
//   DCACHE_stall_i      cache busy; a request completes in the first cycle low
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] MemAddr_i,
  input  logic [31:0] MemWriteData_i,
  output logic [31:0] MemReadData_o,
  output logic        Stall_o,
  output logic        Misaligned_o,
  output logic        Timeout_o,
  output logic        DCACHE_ren_o,
  output logic        DCACHE_wen_o,
  output logic [29:0] DCACHE_addr_o,
  output logic [31:0] DCACHE_wdata_o,
  input  logic [31:0] DCACHE_rdata_i,
  input  logic        DCACHE_stall_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    DONE
  } state_t;

  // funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state, stateNext;
  logic [1:0]  offQ, offD;          // byte offset within the word
  logic [2:0]  funct3Q, funct3D;
  logic [15:0] wdataQ, wdataD;      // only the low half is ever merged
  logic [7:0]  waitCnt, waitD;

  logic [31:0] readD;
  logic        misD, timeoutD, renD, wenD;
  logic [29:0] addrD;
  logic [31:0] cacheWdataD;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic isLegal(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (rd && wr) begin
      ok = 1'b0;
    end else if (rd) begin
      case (f3)
        F3_B, F3_BU: ok = 1'b1;
        F3_H, F3_HU: ok = ~off[0];
        F3_W:        ok = (off == 2'b00);
        default:     ok = 1'b0;
      endcase
    end else if (wr) begin
      case (f3)
        F3_B:    ok = 1'b1;
        F3_H:    ok = ~off[0];
        F3_W:    ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Little-endian lane select: byte k lives in bits [8k+7:8k].
  function automatic logic [31:0] formatLoad(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of the old word with the store data.
  function automatic logic [31:0] mergeStore(input logic [31:0] word,
                                             input logic [15:0] wdata,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
    logic [31:0] mask;
    logic [31:0] r;
    if (f3 == F3_H) begin
      r = off[1] ? {wdata, word[15:0]} : {word[31:16], wdata};
    end else begin
      mask = 32'h0000_00FF << {off, 3'b000};
      r    = (word & ~mask) | ({24'h0, wdata[7:0]} << {off, 3'b000});
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left one
    // unassigned would infer a latch instead of combinational logic.
    stateNext   = state;
    offD        = offQ;
    funct3D     = funct3Q;
    wdataD      = wdataQ;
    waitD       = waitCnt;
    readD       = MemReadData_o;
    misD        = 1'b0;
    timeoutD    = Timeout_o;
    renD        = DCACHE_ren_o;
    wenD        = DCACHE_wen_o;
    addrD       = DCACHE_addr_o;
    cacheWdataD = DCACHE_wdata_o;
    Stall_o     = 1'b0;

    // Wait counter: consecutive busy cycles of the current cache request.
    // It saturates so a very long wait cannot wrap back below MAX_WAIT.
    if (state inside {RD, WR, RMW_RD, RMW_WR}) begin
      if (DCACHE_stall_i) begin
        if (waitCnt != 8'hFF) begin
          waitD = waitCnt + 8'd1;
        end
        if (waitD == MAX_WAIT_C) begin
          timeoutD = 1'b1;
        end
      end else begin
        waitD = 8'd0;
      end
    end

    case (state)
      IDLE: begin
        if (MemRead_i || MemWrite_i) begin
          Stall_o = 1'b1;
          offD    = MemAddr_i[1:0];
          funct3D = Funct3_i;
          wdataD  = MemWriteData_i[15:0];
          addrD   = MemAddr_i[31:2];
          if (!isLegal(MemRead_i, MemWrite_i, Funct3_i, MemAddr_i[1:0])) begin
            stateNext = DONE;
            misD      = 1'b1;
            readD     = 32'h0;
          end else if (MemRead_i) begin
            stateNext = RD;
            renD      = 1'b1;
          end else if (Funct3_i == F3_W) begin
            stateNext   = WR;
            wenD        = 1'b1;
            cacheWdataD = MemWriteData_i;
          end else begin
            stateNext = RMW_RD;
            renD      = 1'b1;
          end
        end
      end

      RD: begin
        Stall_o = 1'b1;
        if (!DCACHE_stall_i) begin
          renD      = 1'b0;
          readD     = formatLoad(DCACHE_rdata_i, funct3Q, offQ);
          stateNext = DONE;
        end
      end

      RMW_RD: begin
        Stall_o = 1'b1;
        if (!DCACHE_stall_i) begin
          renD        = 1'b0;
          wenD        = 1'b1;
          cacheWdataD = mergeStore(DCACHE_rdata_i, wdataQ, funct3Q, offQ);
          stateNext   = RMW_WR;
        end
      end

      WR, RMW_WR: begin
        Stall_o = 1'b1;
        if (!DCACHE_stall_i) begin
          wenD      = 1'b0;
          stateNext = DONE;
        end
      end

      // One cycle with Stall_o low lets the pipeline advance past this access.
      DONE: stateNext = IDLE;

      default: stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      offQ           <= 2'b00;
      funct3Q        <= 3'b000;
      wdataQ         <= 16'h0;
      waitCnt        <= 8'd0;
      MemReadData_o  <= 32'h0;
      Misaligned_o   <= 1'b0;
      Timeout_o      <= 1'b0;
      DCACHE_ren_o   <= 1'b0;
      DCACHE_wen_o   <= 1'b0;
      DCACHE_addr_o  <= 30'h0;
      DCACHE_wdata_o <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking ones would let later lines see updated state.
      state          <= stateNext;
      offQ           <= offD;
      funct3Q        <= funct3D;
      wdataQ         <= wdataD;
      waitCnt        <= waitD;
      MemReadData_o  <= readD;
      Misaligned_o   <= misD;
      Timeout_o      <= timeoutD;
      DCACHE_ren_o   <= renD;
      DCACHE_wen_o   <= wenD;
      DCACHE_addr_o  <= addrD;
      DCACHE_wdata_o <= cacheWdataD;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Table-driven bench for mem_access_unit. Each record describes one access
// (request, cache read word, cache busy cycles) and the expected result, stall
// length, request counts and timeout state. A second instance with MAX_WAIT=4
// shares the inputs to exercise the timeout at a small threshold. Hand-written
// sequences cover the MAX_WAIT=255 boundary and a reset in the middle of an RMW.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk_i;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [2:0]  Funct3_i;
  logic [31:0] MemAddr_i;
  logic [31:0] MemWriteData_i;
  logic [31:0] DCACHE_rdata_i;
  logic        DCACHE_stall_i;

  logic [31:0] MemReadData_o;
  logic        Stall_o;
  logic        Misaligned_o;
  logic        Timeout_o;
  logic        DCACHE_ren_o;
  logic        DCACHE_wen_o;
  logic [29:0] DCACHE_addr_o;
  logic [31:0] DCACHE_wdata_o;

  logic [31:0] readData4;
  logic        stall4, mis4, timeout4, ren4, wen4;
  logic [29:0] addr4;
  logic [31:0] wdata4;

  int nCompared   = 0;
  int nMismatched = 0;

  mem_access_unit dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .MemRead_i      (MemRead_i),
    .MemWrite_i     (MemWrite_i),
    .Funct3_i       (Funct3_i),
    .MemAddr_i      (MemAddr_i),
    .MemWriteData_i (MemWriteData_i),
    .MemReadData_o  (MemReadData_o),
    .Stall_o        (Stall_o),
    .Misaligned_o   (Misaligned_o),
    .Timeout_o      (Timeout_o),
    .DCACHE_ren_o   (DCACHE_ren_o),
    .DCACHE_wen_o   (DCACHE_wen_o),
    .DCACHE_addr_o  (DCACHE_addr_o),
    .DCACHE_wdata_o (DCACHE_wdata_o),
    .DCACHE_rdata_i (DCACHE_rdata_i),
    .DCACHE_stall_i (DCACHE_stall_i)
  );

  mem_access_unit #(.MAX_WAIT(4)) dut4 (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .MemRead_i      (MemRead_i),
    .MemWrite_i     (MemWrite_i),
    .Funct3_i       (Funct3_i),
    .MemAddr_i      (MemAddr_i),
    .MemWriteData_i (MemWriteData_i),
    .MemReadData_o  (readData4),
    .Stall_o        (stall4),
    .Misaligned_o   (mis4),
    .Timeout_o      (timeout4),
    .DCACHE_ren_o   (ren4),
    .DCACHE_wen_o   (wen4),
    .DCACHE_addr_o  (addr4),
    .DCACHE_wdata_o (wdata4),
    .DCACHE_rdata_i (DCACHE_rdata_i),
    .DCACHE_stall_i (DCACHE_stall_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          stalls;     // busy cycles applied to the first cache request
    logic [31:0] expRead;
    logic [31:0] expWdata;
    logic [29:0] expAddr;
    int          expMis;     // Misaligned_o high cycles
    int          expStall;   // Stall_o high cycles
    int          expRen;
    int          expWen;
    logic        expTo4;     // Timeout_o of the MAX_WAIT=4 instance afterwards
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " MemReadData"}, MemReadData_o, 32'h0);
    check({tag, " Stall"}, {31'h0, Stall_o}, 32'h0);
    check({tag, " Misaligned"}, {31'h0, Misaligned_o}, 32'h0);
    check({tag, " Timeout"}, {31'h0, Timeout_o}, 32'h0);
    check({tag, " ren"}, {31'h0, DCACHE_ren_o}, 32'h0);
    check({tag, " wen"}, {31'h0, DCACHE_wen_o}, 32'h0);
    check({tag, " addr"}, {2'b00, DCACHE_addr_o}, 32'h0);
    check({tag, " wdata"}, DCACHE_wdata_o, 32'h0);
    check({tag, " Timeout4"}, {31'h0, timeout4}, 32'h0);
  endtask

  // Presents one access from a negedge and plays the cache until the DONE
  // cycle (first sampled cycle with Stall_o low), then one idle cycle.
  task automatic doAccess(input vec_t v, output int nStall, output int nRen,
                          output int nWen, output int nMis,
                          output logic [31:0] rdOut, output logic [31:0] wdOut,
                          output logic [29:0] addrOut, output logic done);
    int stallLeft;
    stallLeft      = v.stalls;
    nStall         = 0;
    nRen           = 0;
    nWen           = 0;
    nMis           = 0;
    rdOut          = 32'h0;
    wdOut          = 32'h0;
    addrOut        = 30'h0;
    done           = 1'b0;
    MemRead_i      = v.rd;
    MemWrite_i     = v.wr;
    Funct3_i       = v.f3;
    MemAddr_i      = v.addr;
    MemWriteData_i = v.wdata;
    DCACHE_rdata_i = v.rword;
    DCACHE_stall_i = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      #1;
      if (DCACHE_ren_o || DCACHE_wen_o) begin
        addrOut = DCACHE_addr_o;
        if (stallLeft > 0) begin
          DCACHE_stall_i = 1'b1;
          stallLeft--;
        end else begin
          DCACHE_stall_i = 1'b0;
        end
        if (DCACHE_ren_o) nRen++;
        if (DCACHE_wen_o) begin
          nWen++;
          if (!DCACHE_stall_i) wdOut = DCACHE_wdata_o;
        end
      end else begin
        DCACHE_stall_i = 1'b0;
      end
      if (Misaligned_o) nMis++;
      if (Stall_o) begin
        nStall++;
      end else begin
        done       = 1'b1;
        rdOut      = MemReadData_o;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
      end
      @(negedge clk_i);
    end
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    #1;
    if (Misaligned_o) nMis++;
    @(negedge clk_i);
  endtask

  task automatic runVec(input string tag, input vec_t v, input logic expTo);
    int          nStall, nRen, nWen, nMis;
    logic [31:0] rdOut, wdOut;
    logic [29:0] addrOut;
    logic        done;
    doAccess(v, nStall, nRen, nWen, nMis, rdOut, wdOut, addrOut, done);
    check({tag, " completed"}, {31'h0, done}, 32'h1);
    check({tag, " MemReadData"}, rdOut, v.expRead);
    check({tag, " stall cycles"}, nStall, v.expStall);
    check({tag, " ren cycles"}, nRen, v.expRen);
    check({tag, " wen cycles"}, nWen, v.expWen);
    check({tag, " misaligned cycles"}, nMis, v.expMis);
    if (v.wr && v.expWen > 0) check({tag, " cache wdata"}, wdOut, v.expWdata);
    if (v.expRen + v.expWen > 0) check({tag, " cache addr"}, {2'b00, addrOut}, {2'b00, v.expAddr});
    check({tag, " Timeout"}, {31'h0, Timeout_o}, {31'h0, expTo});
    check({tag, " Timeout4"}, {31'h0, timeout4}, {31'h0, v.expTo4});
  endtask

  initial begin
    vec_t v;

    //                rd    wr    f3    addr          wdata         rword         st  expRead       expWdata      expAddr  mis stl ren wen to4
    vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 32'h0,        30'h41, 0, 2, 1, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0000_0200, 32'h0,        32'h8070_F0A5, 0, 32'hFFFF_FFA5, 32'h0,        30'h80, 0, 2, 1, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h0000_0203, 32'h0,        32'h8070_F0A5, 0, 32'h0000_0080, 32'h0,        30'h80, 0, 2, 1, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd1, 32'h0000_0202, 32'h0,        32'h8070_F0A5, 0, 32'hFFFF_8070, 32'h0,        30'h80, 0, 2, 1, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd5, 32'h0000_0200, 32'h0,        32'h8070_F0A5, 0, 32'h0000_F0A5, 32'h0,        30'h80, 0, 2, 1, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0000_0201, 32'h0,        32'h8070_F0A5, 0, 32'hFFFF_FFF0, 32'h0,        30'h80, 0, 2, 1, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h0000_0202, 32'h0,        32'h8070_F0A5, 0, 32'h0000_0070, 32'h0,        30'h80, 0, 2, 1, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd1, 32'h0000_0200, 32'h0,        32'h8070_F0A5, 0, 32'hFFFF_F0A5, 32'h0,        30'h80, 0, 2, 1, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd5, 32'h0000_0202, 32'h0,        32'h8070_F0A5, 0, 32'h0000_8070, 32'h0,        30'h80, 0, 2, 1, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd0, 32'h0000_0301, 32'h0000_00AB, 32'h1122_3344, 0, 32'h0000_8070, 32'h1122_AB44, 30'hC0, 0, 3, 1, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd1, 32'h0000_0302, 32'hCAFE_BEEF, 32'h1122_3344, 0, 32'h0000_8070, 32'hBEEF_3344, 30'hC0, 0, 3, 1, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd2, 32'h0000_0304, 32'h1234_5678, 32'h0,        0, 32'h0000_8070, 32'h1234_5678, 30'hC1, 0, 2, 0, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd0, 32'h0000_0303, 32'h0000_005A, 32'h1122_3344, 3, 32'h0000_8070, 32'h5A22_3344, 30'hC0, 0, 6, 4, 1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 20, 32'hDEAD_BEEF, 32'h0,       30'h41, 0, 22, 21, 0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'h0,        32'hDEAD_BEEF, 0, 32'h0,         32'h0,        30'h0,  1, 1, 0, 0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h0000_0203, 32'h0,        32'h8070_F0A5, 0, 32'h0000_0080, 32'h0,        30'h80, 0, 2, 1, 0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 3'd1, 32'h0000_0101, 32'h0000_1234, 32'h0,        0, 32'h0,         32'h0,        30'h0,  1, 1, 0, 0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h0000_0203, 32'h0,        32'h8070_F0A5, 0, 32'h0000_0080, 32'h0,        30'h80, 0, 2, 1, 0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0,         32'h0,        30'h0,  1, 1, 0, 0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0000_0203, 32'h0,        32'h8070_F0A5, 0, 32'hFFFF_FF80, 32'h0,        30'h80, 0, 2, 1, 0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 3'd2, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0,         32'h0,        30'h0,  1, 1, 0, 0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 3'd4, 32'h0000_0000, 32'h0,        32'h0,        0, 32'h0,         32'h0,        30'h0,  1, 1, 0, 0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 3'd1, 32'h0000_0300, 32'h0000_BEEF, 32'h1122_3344, 0, 32'h0,        32'h1122_BEEF, 30'hC0, 0, 3, 1, 1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h0000_0108, 32'h0,        32'h0BAD_F00D, 10, 32'h0BAD_F00D, 32'h0,       30'h42, 0, 12, 11, 0, 1'b1});

    rst_i          = 1'b0;
    MemRead_i      = 1'b0;
    MemWrite_i     = 1'b0;
    Funct3_i       = 3'd0;
    MemAddr_i      = 32'h0;
    MemWriteData_i = 32'h0;
    DCACHE_rdata_i = 32'h0;
    DCACHE_stall_i = 1'b0;

    #3;
    checkAllZero("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    foreach (vecs[i]) begin
      runVec($sformatf("v%0d", i), vecs[i], 1'b0);
    end

    // MAX_WAIT=255 boundary: 254 busy cycles stay below, 255 reach it.
    v = '{1'b1, 1'b0, 3'd2, 32'h0000_0110, 32'h0, 32'h0000_1111, 254, 32'h0000_1111,
          32'h0, 30'h44, 0, 256, 255, 0, 1'b1};
    runVec("wait254", v, 1'b0);
    v = '{1'b1, 1'b0, 3'd2, 32'h0000_0114, 32'h0, 32'h0000_2222, 255, 32'h0000_2222,
          32'h0, 30'h45, 0, 257, 256, 0, 1'b1};
    runVec("wait255", v, 1'b1);
    v = '{1'b1, 1'b0, 3'd4, 32'h0000_0118, 32'h0, 32'h0000_0033, 0, 32'h0000_0033,
          32'h0, 30'h46, 0, 2, 1, 0, 1'b1};
    runVec("sticky", v, 1'b1);

    // Reset while an SB is waiting in its read phase.
    MemRead_i      = 1'b0;
    MemWrite_i     = 1'b1;
    Funct3_i       = 3'd0;
    MemAddr_i      = 32'h0000_0305;
    MemWriteData_i = 32'h0000_0077;
    DCACHE_rdata_i = 32'h1122_3344;
    DCACHE_stall_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("rmw ren asserted", {31'h0, DCACHE_ren_o}, 32'h1);
    check("rmw stall asserted", {31'h0, Stall_o}, 32'h1);
    check("rmw addr", {2'b00, DCACHE_addr_o}, 32'h0000_00C1);
    @(negedge clk_i);
    rst_i      = 1'b0;
    MemWrite_i = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk_i);
    rst_i          = 1'b1;
    DCACHE_stall_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("post-reset ren", {31'h0, DCACHE_ren_o}, 32'h0);
    check("post-reset wen", {31'h0, DCACHE_wen_o}, 32'h0);
    check("post-reset stall", {31'h0, Stall_o}, 32'h0);
    @(negedge clk_i);
    v = '{1'b1, 1'b0, 3'd2, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF,
          32'h0, 30'h41, 0, 2, 1, 0, 1'b0};
    runVec("after reset", v, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
